// File: rtl/sram_ctrl_pkg.sv
// Shared widths, FSM state encoding and requester id type for the SRAM
// arbiter and its round-robin sub-arbiter.
package sram_ctrl_pkg;

    localparam int unsigned SRAM_ADDR_W = 8;
    localparam int unsigned SRAM_DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StSense,
        StCapture
    } sram_state_e;

    typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The pointer remembers the last requester
// served and moves only when the granted request is accepted.
module rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    req_id_t last_q, last_d;

    always_comb begin
        grant  = 2'b00;
        last_d = last_q;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (advance) begin
            last_d = grant[1];
        end
    end

    // Reset as if requester 1 was served last, so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin controller for the 256 x 32 compiled SRAM macro:
// sequences write/sense strobes and returns read data with a one-cycle pulse.
module sram_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                busy,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_din,
    input  logic [DATA_W-1:0]   sram_dout,
    output logic                sram_write_en,
    output logic                sram_sense_en
);

    sram_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    req_id_t           id_q, id_d;
    logic              write_en_q, write_en_d;
    logic              sense_en_q, sense_en_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              busy_q, busy_d;

    logic [1:0] grant;
    logic       accept;
    req_id_t    sel;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    assign req_ready = (state_q == StIdle) ? grant : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign sel       = req_ready[1];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        din_d       = din_q;
        id_d        = id_q;
        rsp_data_d  = rsp_data_q;
        write_en_d  = 1'b0;
        sense_en_d  = 1'b0;
        rsp_valid_d = 2'b00;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    id_d       = sel;
                    addr_d     = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                    din_d      = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    write_en_d = req_we[sel];
                    sense_en_d = !req_we[sel];
                    state_d    = req_we[sel] ? StWrite : StSense;
                end
            end
            StWrite: state_d = StIdle;
            StSense: state_d = StCapture;
            StCapture: begin
                rsp_data_d        = sram_dout;
                rsp_valid_d[id_q] = 1'b1;
                state_d           = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            din_q       <= '0;
            id_q        <= 1'b0;
            write_en_q  <= 1'b0;
            sense_en_q  <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            id_q        <= id_d;
            write_en_q  <= write_en_d;
            sense_en_q  <= sense_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign sram_addr     = addr_q;
    assign sram_din      = din_q;
    assign sram_write_en = write_en_q;
    assign sram_sense_en = sense_en_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural model of the SRAM macro.
`timescale 1ns/1ps
module tb_sram_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rsp_data, sram_din, sram_dout;
    logic [7:0]  sram_addr;
    logic        busy, sram_write_en, sram_sense_en;

    logic [31:0] mem [256];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          acc_c[$];
    int          acc_p[$];
    int          rsp_c[$];
    int          rsp_p[$];
    logic [31:0] rsp_d[$];

    sram_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .busy          (busy),
        .sram_addr     (sram_addr),
        .sram_din      (sram_din),
        .sram_dout     (sram_dout),
        .sram_write_en (sram_write_en),
        .sram_sense_en (sram_sense_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Macro model: write on the strobe edge, dout registered on the sense edge.
    always @(posedge clk) begin
        if (sram_write_en) mem[sram_addr] <= sram_din;
        if (sram_sense_en) sram_dout <= mem[sram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        check("strobe_excl", 32'(sram_write_en & sram_sense_en), 32'd0);
        check("rsp_onehot", 32'(rsp_valid == 2'b11), 32'd0);
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                acc_c.push_back(cyc);
                acc_p.push_back(i);
            end
        end
        if (rsp_valid != 2'b00) begin
            rsp_c.push_back(cyc);
            rsp_p.push_back(rsp_valid[1] ? 1 : 0);
            rsp_d.push_back(rsp_data);
        end
    end

    task automatic clear_logs();
        acc_c.delete();
        acc_p.delete();
        rsp_c.delete();
        rsp_p.delete();
        rsp_d.delete();
    endtask

    task automatic check_reset_outputs(input string pre);
        check({pre, "_addr"}, 32'(sram_addr), 32'd0);
        check({pre, "_din"}, sram_din, 32'd0);
        check({pre, "_we"}, 32'(sram_write_en), 32'd0);
        check({pre, "_se"}, 32'(sram_sense_en), 32'd0);
        check({pre, "_rspv"}, 32'(rsp_valid), 32'd0);
        check({pre, "_rspd"}, rsp_data, 32'd0);
        check({pre, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic probe_ready(input logic [1:0] v, input logic [31:0] exp, input string tag);
        req_valid = v;
        #1;
        check(tag, 32'(req_ready), exp);
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    // Entered at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int p, input logic we, input logic [7:0] a,
                         input logic [31:0] d, output int acc);
        req_we[p]             = we;
        req_addr[p*8 +: 8]    = a;
        req_wdata[p*32 +: 32] = d;
        req_valid[p]          = 1'b1;
        acc = -1;
        for (int k = 0; k < 20 && acc < 0; k++) begin
            #1;
            if (req_ready[p]) acc = cyc;
            @(negedge clk);
        end
        req_valid[p] = 1'b0;
        if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int wa[4];
        int ra[4];
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        check("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        probe_ready(2'b11, 32'h1, "tie_after_reset");
        probe_ready(2'b10, 32'h2, "single_req1");
        probe_ready(2'b01, 32'h1, "single_req0");

        // Single write then read.
        issue(0, 1'b1, 8'h05, 32'hDEADBEEF, t);
        check("wr_we", 32'(sram_write_en), 32'd1);
        check("wr_addr", 32'(sram_addr), 32'h05);
        check("wr_din", sram_din, 32'hDEADBEEF);
        check("wr_busy", 32'(busy), 32'd1);
        check("wr_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("wr_we_off", 32'(sram_write_en), 32'd0);
        check("wr_busy_off", 32'(busy), 32'd0);
        issue(0, 1'b0, 8'h05, 32'h0, t);
        check("rd_se", 32'(sram_sense_en), 32'd1);
        check("rd_we", 32'(sram_write_en), 32'd0);
        @(negedge clk);
        check("rd_se_off", 32'(sram_sense_en), 32'd0);
        check("rd_rspv_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("rd_rspv", 32'(rsp_valid), 32'h1);
        check("rd_rspd", rsp_data, 32'hDEADBEEF);
        check("rd_lat", 32'(cyc - t), 32'd3);
        @(negedge clk);
        check("rd_rspv_pulse", 32'(rsp_valid), 32'd0);
        check("rd_rspd_hold", rsp_data, 32'hDEADBEEF);

        // Contention fairness on preloaded words.
        issue(0, 1'b1, 8'h10, 32'h11110000, t);
        @(negedge clk);
        issue(1, 1'b1, 8'h20, 32'h22220000, t);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_logs();
        req_we    = 2'b00;
        req_addr  = {8'h20, 8'h10};
        req_valid = 2'b11;
        repeat (13) @(negedge clk);
        req_valid = 2'b00;
        repeat (6) @(negedge clk);
        check("cont_acc_n", 32'(acc_c.size() >= 4), 32'd1);
        check("cont_rsp_n", 32'(rsp_c.size() >= 4), 32'd1);
        if (acc_c.size() >= 4 && rsp_c.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("cont_grant", 32'(acc_p[i]), 32'(i % 2));
                check("cont_rsp_id", 32'(rsp_p[i]), 32'(i % 2));
                check("cont_rsp_data", rsp_d[i], (i % 2 == 1) ? 32'h22220000 : 32'h11110000);
                check("cont_rsp_lat", 32'(rsp_c[i] - acc_c[i]), 32'd3);
                if (i > 0) check("cont_acc_gap", 32'(acc_c[i] - acc_c[i-1]), 32'd3);
            end
        end

        // Back-to-back throughput at the top of the array.
        for (int i = 0; i < 4; i++) issue(1, 1'b1, 8'(8'hFC + i), 32'hA5A50000 + 32'(i), wa[i]);
        clear_logs();
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 8'(8'hFC + i), 32'h0, ra[i]);
        repeat (4) @(negedge clk);
        check("tp_wr_to_rd", 32'(ra[0] - wa[3]), 32'd2);
        for (int i = 1; i < 4; i++) begin
            check("tp_wr_gap", 32'(wa[i] - wa[i-1]), 32'd2);
            check("tp_rd_gap", 32'(ra[i] - ra[i-1]), 32'd3);
        end
        check("tp_rsp_n", 32'(rsp_c.size()), 32'd4);
        if (rsp_c.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("tp_rsp_data", rsp_d[i], 32'hA5A50000 + 32'(i));
                check("tp_rsp_id", 32'(rsp_p[i]), 32'd1);
                check("tp_rsp_lat", 32'(rsp_c[i] - ra[i]), 32'd3);
            end
        end

        // Random mixed traffic; the monitor checks exclusivity every cycle.
        for (int i = 0; i < 10000; i++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_we    = 2'($urandom_range(0, 3));
            req_addr  = 16'($urandom);
            req_wdata = {$urandom, $urandom};
            @(negedge clk);
        end
        req_valid = 2'b00;
        repeat (4) @(negedge clk);

        // Reset mid-read.
        issue(0, 1'b1, 8'h33, 32'h12345678, t);
        @(negedge clk);
        issue(0, 1'b0, 8'h33, 32'h0, t);
        repeat (2) @(negedge clk);
        check("pre_rst_rspd", rsp_data, 32'h12345678);
        issue(0, 1'b0, 8'h33, 32'h0, t);
        check("mid_rd_se", 32'(sram_sense_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rd");
        clear_logs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_rd_no_rsp", 32'(rsp_c.size()), 32'd0);
        probe_ready(2'b11, 32'h1, "tie_after_mid_rst");

        // Reset mid-write.
        issue(1, 1'b1, 8'h44, 32'hCAFEF00D, t);
        check("mid_wr_we", 32'(sram_write_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_wr_we_off", 32'(sram_write_en), 32'd0);
        check("mid_wr_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1, 1'b1, 8'h44, 32'h0BADCAFE, t);
        @(negedge clk);
        issue(1, 1'b0, 8'h44, 32'h0, t);
        repeat (2) @(negedge clk);
        check("post_wr_rspv", 32'(rsp_valid), 32'h2);
        check("post_wr_rspd", rsp_data, 32'h0BADCAFE);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
